// File: rtl/riscv_run_ctrl_pkg.sv
// Shared types and constants for the run controller: controller states and
// the tohost exit-write encoding.
package riscv_tb_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } run_state_e;

  // Bit 0 of a tohost store marks it as an exit write; the rest is the exit code.
  localparam int unsigned TOHOST_EXIT_BIT = 0;

  function automatic int unsigned exitCodeBits(input int unsigned regBits);
    return regBits - 1;
  endfunction

endpackage

// File: rtl/riscv_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: holds the core in reset, lets it run while counting cycles
// and retired instructions, and latches the pass/fail/timeout result.
module riscv_run_ctrl
  import riscv_tb_pkg::*;
#(
  parameter int unsigned        RegBits    = 32,
  parameter int unsigned        AddrBits   = 5,
  parameter int unsigned        CntBits    = 32,
  parameter int unsigned        RstCycles  = 4,
  parameter int unsigned        MaxCycles  = 100000,
  parameter logic [RegBits-1:0] TohostAddr = RegBits'(32'h0000_1000)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              restart_i,
  input  logic                              mem_we_i,
  input  logic [RegBits-1:0]                mem_addr_i,
  input  logic [RegBits-1:0]                mem_wdata_i,
  input  logic                              retire_i,
  output logic                              core_rst_no,
  output logic                              running_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic                              timeout_o,
  output logic [exitCodeBits(RegBits)-1:0]  fail_code_o,
  output logic [CntBits-1:0]                cycle_cnt_o,
  output logic [CntBits-1:0]                instret_o
);

  localparam int unsigned HoldBits = $clog2(RstCycles + 1);
  localparam int unsigned CodeBits = exitCodeBits(RegBits);

  if (RstCycles < 1 || MaxCycles < 1 || AddrBits < 1 ||
      64'(MaxCycles) >= (64'd1 << CntBits)) begin : gen_bad_params
    $error("riscv_run_ctrl: illegal parameter combination");
  end

  run_state_e          state_q, state_d;
  logic [CodeBits-1:0] failCode_q, failCode_d;
  logic                run_q, done_q, pass_q, timeout_q;

  logic [HoldBits-1:0] holdCnt;
  logic [CntBits-1:0]  cycleCnt, instretCnt;
  logic                inRun, inHold, exitWrite;
  logic [CodeBits-1:0] exitCode;

  assign inRun     = (state_q == RUN);
  assign inHold    = (state_q == HOLD);
  assign exitCode  = mem_wdata_i[RegBits-1:TOHOST_EXIT_BIT+1];
  assign exitWrite = inRun && mem_we_i && (mem_addr_i == TohostAddr) &&
                     mem_wdata_i[TOHOST_EXIT_BIT];

  // The hold counter is parked at zero outside HOLD so every entry starts fresh.
  sat_counter #(.Width(HoldBits)) u_hold_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (restart_i || !inHold),
    .en_i   (inHold),
    .cnt_o  (holdCnt)
  );

  sat_counter #(.Width(CntBits)) u_cycle_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (restart_i),
    .en_i   (inRun),
    .cnt_o  (cycleCnt)
  );

  sat_counter #(.Width(CntBits)) u_instret_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (restart_i),
    .en_i   (inRun && retire_i),
    .cnt_o  (instretCnt)
  );

  // Restart overrides everything; an exit write outranks the timeout.
  always_comb begin
    state_d    = state_q;
    failCode_d = failCode_q;
    unique case (state_q)
      HOLD: begin
        if (holdCnt == HoldBits'(RstCycles - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (exitWrite) begin
          state_d    = (exitCode == '0) ? PASS : FAIL;
          failCode_d = exitCode;
        end else if (cycleCnt == CntBits'(MaxCycles - 1)) begin
          state_d = TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
    if (restart_i) begin
      state_d    = HOLD;
      failCode_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HOLD;
      failCode_q <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      failCode_q <= failCode_d;
      run_q      <= (state_d == RUN);
      done_q     <= (state_d == PASS) || (state_d == FAIL) || (state_d == TIMEOUT);
      pass_q     <= (state_d == PASS);
      timeout_q  <= (state_d == TIMEOUT);
    end
  end

  assign core_rst_no = run_q;
  assign running_o   = run_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign fail_code_o = failCode_q;
  assign cycle_cnt_o = cycleCnt;
  assign instret_o   = instretCnt;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: a vector table, hand-written corner sequences and
// a randomized run checked against a behavioural model of the run controller.
module tb_riscv_run_ctrl;

  localparam int          RST_CYCLES = 4;
  localparam int          MAX_CYCLES = 20;
  localparam logic [31:0] TOHOST     = 32'h0000_1000;

  typedef struct {
    logic        restart;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        retire;
  } stim_t;

  typedef struct {
    logic        coreRstN;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] code;
    logic [31:0] cycles;
    logic [31:0] instret;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        restart = 1'b0, memWe = 1'b0, retire = 1'b0;
  logic [31:0] memAddr = '0, memWdata = '0;

  logic        coreRstNA, runningA, doneA, passA, timeoutA;
  logic [30:0] failCodeA;
  logic [31:0] cycleA, instretA;
  logic        coreRstNB, runningB, doneB, passB, timeoutB;
  logic [30:0] failCodeB;
  logic [3:0]  cycleB, instretB;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 = core held in reset, 1 = running, 2 = finished.
  int          mPhase, mHold;
  longint      mCycles, mInstret;
  logic        mPass, mTimeout;
  logic [30:0] mCode;

  riscv_run_ctrl #(.RstCycles(RST_CYCLES), .MaxCycles(MAX_CYCLES)) dutA (
    .clk_i(clk), .rst_ni(rstN), .restart_i(restart), .mem_we_i(memWe),
    .mem_addr_i(memAddr), .mem_wdata_i(memWdata), .retire_i(retire),
    .core_rst_no(coreRstNA), .running_o(runningA), .done_o(doneA), .pass_o(passA),
    .timeout_o(timeoutA), .fail_code_o(failCodeA), .cycle_cnt_o(cycleA),
    .instret_o(instretA)
  );

  riscv_run_ctrl #(.CntBits(4), .RstCycles(RST_CYCLES), .MaxCycles(15)) dutB (
    .clk_i(clk), .rst_ni(rstN), .restart_i(restart), .mem_we_i(memWe),
    .mem_addr_i(memAddr), .mem_wdata_i(memWdata), .retire_i(retire),
    .core_rst_no(coreRstNB), .running_o(runningB), .done_o(doneB), .pass_o(passB),
    .timeout_o(timeoutB), .fail_code_o(failCodeB), .cycle_cnt_o(cycleB),
    .instret_o(instretB)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input logic rs, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ret);
    stim_t s;
    s.restart = rs; s.we = we; s.addr = addr; s.wdata = wdata; s.retire = ret;
    return s;
  endfunction

  function automatic exp_t ex(input logic core, input logic done, input logic pass,
                              input logic tmo, input logic [30:0] code,
                              input logic [31:0] cyc, input logic [31:0] ins);
    exp_t e;
    e.coreRstN = core; e.done = done; e.pass = pass; e.timeout = tmo;
    e.code = code; e.cycles = cyc; e.instret = ins;
    return e;
  endfunction

  function automatic vec_t mk(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    return v;
  endfunction

  task automatic modelReset();
    mPhase = 0; mHold = 0; mCycles = 0; mInstret = 0;
    mPass = 1'b0; mTimeout = 1'b0; mCode = '0;
  endtask

  task automatic modelStep(input stim_t s);
    logic isExit, lastCycle;
    if (s.restart) begin
      modelReset();
    end else if (mPhase == 0) begin
      mHold++;
      if (mHold == RST_CYCLES) mPhase = 1;
    end else if (mPhase == 1) begin
      isExit    = s.we && (s.addr == TOHOST) && s.wdata[0];
      lastCycle = (mCycles == MAX_CYCLES - 1);
      if (mCycles < 64'hFFFF_FFFF) mCycles++;
      if (s.retire && mInstret < 64'hFFFF_FFFF) mInstret++;
      if (isExit) begin
        mPhase = 2;
        mCode  = s.wdata[31:1];
        mPass  = (s.wdata[31:1] == 0);
      end else if (lastCycle) begin
        mPhase   = 2;
        mTimeout = 1'b1;
      end
    end
  endtask

  function automatic exp_t modelExpected();
    return ex(mPhase == 1, mPhase == 2, mPass, mTimeout, mCode,
              32'(mCycles), 32'(mInstret));
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField({tag, ".core_rst_no"}, 32'(coreRstNA), 32'(e.coreRstN));
    checkField({tag, ".running"},     32'(runningA),  32'(e.coreRstN));
    checkField({tag, ".done"},        32'(doneA),     32'(e.done));
    checkField({tag, ".pass"},        32'(passA),     32'(e.pass));
    checkField({tag, ".timeout"},     32'(timeoutA),  32'(e.timeout));
    checkField({tag, ".fail_code"},   32'(failCodeA), 32'(e.code));
    checkField({tag, ".cycle_cnt"},   cycleA,         e.cycles);
    checkField({tag, ".instret"},     instretA,       e.instret);
  endtask

  // Drives one cycle of inputs, advances the model, and returns just after the edge.
  task automatic applyStimulus(input stim_t s);
    restart  = s.restart;
    memWe    = s.we;
    memAddr  = s.addr;
    memWdata = s.wdata;
    retire   = s.retire;
    modelStep(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t  table_q[$];
    stim_t idle, rs;
    exp_t  zero;

    idle = st(0, 0, 0, 0, 0);
    rs   = st(1, 0, 0, 0, 0);
    zero = ex(0, 0, 0, 0, 0, 0, 0);

    // Reset release, pass exit, terminal stickiness, restart, ignored writes, fail exit.
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 1, TOHOST, 32'h1, 1),     ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(1, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(1, 0, 0, 0, 0, 1, 1)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(1, 0, 0, 0, 0, 2, 2)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(1, 0, 0, 0, 0, 3, 2)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(1, 0, 0, 0, 0, 4, 3)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(1, 0, 0, 0, 0, 5, 4)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(1, 0, 0, 0, 0, 6, 4)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(1, 0, 0, 0, 0, 7, 5)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(1, 0, 0, 0, 0, 8, 6)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(1, 0, 0, 0, 0, 9, 6)));
    table_q.push_back(mk(st(0, 1, TOHOST, 32'h1, 1),     ex(0, 1, 1, 0, 0, 10, 7)));
    table_q.push_back(mk(st(0, 1, TOHOST, 32'h7, 1),     ex(0, 1, 1, 0, 0, 10, 7)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(0, 1, 1, 0, 0, 10, 7)));
    table_q.push_back(mk(st(1, 0, 0, 0, 0),              ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 1),              ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(0, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 0, 0, 0, 0),              ex(1, 0, 0, 0, 0, 0, 0)));
    table_q.push_back(mk(st(0, 1, TOHOST, 32'h40, 1),    ex(1, 0, 0, 0, 0, 1, 1)));
    table_q.push_back(mk(st(0, 1, TOHOST + 4, 32'h7, 0), ex(1, 0, 0, 0, 0, 2, 1)));
    table_q.push_back(mk(st(0, 1, TOHOST, 32'h7, 0),     ex(0, 1, 0, 0, 3, 3, 1)));
    table_q.push_back(mk(st(1, 1, TOHOST, 32'h1, 1),     ex(0, 0, 0, 0, 0, 0, 0)));

    #2 rstN = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", zero);
    rstN = 1'b1;

    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i].s);
      checkOutput($sformatf("vec%0d", i), table_q[i].e);
    end

    // Timeout with no exit write.
    repeat (RST_CYCLES) applyStimulus(idle);
    checkOutput("tmo.enter_run", ex(1, 0, 0, 0, 0, 0, 0));
    repeat (MAX_CYCLES - 1) applyStimulus(idle);
    checkOutput("tmo.last_run", ex(1, 0, 0, 0, 0, MAX_CYCLES - 1, 0));
    applyStimulus(idle);
    checkOutput("tmo.hit", ex(0, 1, 0, 1, 0, MAX_CYCLES, 0));
    applyStimulus(st(0, 1, TOHOST, 32'h1, 1));
    checkOutput("tmo.sticky", ex(0, 1, 0, 1, 0, MAX_CYCLES, 0));

    // Exit write on the timeout cycle wins.
    applyStimulus(rs);
    checkOutput("tmoexit.restart", zero);
    repeat (RST_CYCLES) applyStimulus(idle);
    repeat (MAX_CYCLES - 1) applyStimulus(idle);
    checkOutput("tmoexit.last_run", ex(1, 0, 0, 0, 0, MAX_CYCLES - 1, 0));
    applyStimulus(st(0, 1, TOHOST, 32'h1, 0));
    checkOutput("tmoexit.pass", ex(0, 1, 1, 0, 0, MAX_CYCLES, 0));

    // Restart coincident with a failing exit write goes back to HOLD.
    applyStimulus(rs);
    repeat (RST_CYCLES) applyStimulus(idle);
    applyStimulus(st(0, 0, 0, 0, 1));
    applyStimulus(idle);
    checkOutput("rsexit.run", ex(1, 0, 0, 0, 0, 2, 1));
    applyStimulus(st(1, 1, TOHOST, 32'h7, 1));
    checkOutput("rsexit.hold", zero);
    repeat (RST_CYCLES - 1) applyStimulus(idle);
    checkOutput("rsexit.still_hold", zero);
    applyStimulus(idle);
    checkOutput("rsexit.rerun", ex(1, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-run clears outputs between clock edges.
    repeat (5) applyStimulus(st(0, 0, 0, 0, 1));
    checkOutput("async.before", ex(1, 0, 0, 0, 0, 5, 5));
    #2 rstN = 1'b0;
    #1;
    checkOutput("async.cleared", zero);
    checkField("async.B.core_rst_no", 32'(coreRstNB), 0);
    checkField("async.B.instret", 32'(instretB), 0);
    modelReset();

    // Narrow-counter instance: instret climbs to all-ones and never wraps.
    @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (RST_CYCLES) applyStimulus(st(0, 0, 0, 0, 1));
    checkField("sat.B.core_rst_no", 32'(coreRstNB), 1);
    checkField("sat.B.instret_start", 32'(instretB), 0);
    repeat (14) applyStimulus(st(0, 0, 0, 0, 1));
    checkField("sat.B.instret14", 32'(instretB), 14);
    checkField("sat.B.cycle14", 32'(cycleB), 14);
    checkField("sat.B.timeout_early", 32'(timeoutB), 0);
    applyStimulus(st(0, 0, 0, 0, 1));
    checkField("sat.B.timeout", 32'(timeoutB), 1);
    checkField("sat.B.done", 32'(doneB), 1);
    checkField("sat.B.pass", 32'(passB), 0);
    checkField("sat.B.running", 32'(runningB), 0);
    checkField("sat.B.fail_code", 32'(failCodeB), 0);
    checkField("sat.B.instret15", 32'(instretB), 15);
    repeat (3) applyStimulus(st(0, 0, 0, 0, 1));
    checkField("sat.B.instret_hold", 32'(instretB), 15);
    checkField("sat.B.cycle_hold", 32'(cycleB), 15);

    // Randomized traffic against the behavioural model.
    #2 rstN = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 800; i++) begin
      stim_t s;
      s.restart = ($urandom_range(0, 29) == 0);
      s.we      = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0, 1:    s.addr = TOHOST;
        2:       s.addr = TOHOST + 4;
        default: s.addr = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       s.wdata = 32'h1;
        1:       s.wdata = 32'($urandom_range(0, 15));
        default: s.wdata = $urandom;
      endcase
      s.retire = 1'($urandom_range(0, 1));
      applyStimulus(s);
      checkOutput($sformatf("rand%0d", i), modelExpected());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
